// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/register aliases, writeback-source select and MEM-stage FSM states.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    typedef enum logic [1:0] {
        WDAT_ALU  = 2'd0,
        WDAT_LOAD = 2'd1,
        WDAT_NPC  = 2'd2,
        WDAT_LUI  = 2'd3
    } wdatselect_t;

    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_WAIT   = 2'd1,
        MS_HALTED = 2'd2
    } memstate_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of every non-clock signal of the memory stage: EX/MEM inputs, cache request/response, MEM/WB outputs.
interface mem_stage_if
    import cpu_types_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
);
    logic                   enable;
    logic                   flush;
    word_t                  ex_port_o;
    word_t                  ex_rdat2;
    word_t                  ex_npc;
    word_t                  ex_lui_word;
    wdatselect_t            ex_wdatsel;
    regbits_t               ex_wsel;
    logic                   ex_dREN;
    logic                   ex_dWEN;
    logic                   ex_WEN;
    logic                   ex_halt;
    logic                   dhit;
    word_t                  dmemload;
    logic                   dmemREN;
    logic                   dmemWEN;
    word_t                  dmemaddr;
    word_t                  dmemstore;
    logic                   mem_stall;
    word_t                  wb_wdat;
    regbits_t               wb_wsel;
    logic                   wb_WEN;
    logic                   wb_halt;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport mem (
        input  enable, flush, ex_port_o, ex_rdat2, ex_npc, ex_lui_word, ex_wdatsel,
               ex_wsel, ex_dREN, ex_dWEN, ex_WEN, ex_halt, dhit, dmemload,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               wb_wdat, wb_wsel, wb_WEN, wb_halt, stall_cycles
    );

    modport tb (
        output enable, flush, ex_port_o, ex_rdat2, ex_npc, ex_lui_word, ex_wdatsel,
               ex_wsel, ex_dREN, ex_dWEN, ex_WEN, ex_halt, dhit, dmemload,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
               wb_wdat, wb_wsel, wb_WEN, wb_halt, stall_cycles
    );

endinterface

// File: rtl/memwb_reg.sv
// MEM/WB pipeline register: halt-hold, freeze on enable=0, bubble insertion, or capture.
module memwb_reg
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     i_halted,
    input  logic     i_enable,
    input  logic     i_bubble,
    input  word_t    i_wdat,
    input  regbits_t i_wsel,
    input  logic     i_wen,
    input  logic     i_halt,
    output word_t    o_wdat,
    output regbits_t o_wsel,
    output logic     o_wen,
    output logic     o_halt
);

    word_t    r_wdat;
    regbits_t r_wsel;
    logic     r_wen;
    logic     r_halt;

    // Bubble keeps wdat so only the control fields toggle on a squashed slot
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wdat <= '0;
            r_wsel <= '0;
            r_wen  <= 1'b0;
            r_halt <= 1'b0;
        end else if (i_halted) begin
            r_wen  <= 1'b0;
            r_halt <= 1'b1;
        end else if (!i_enable) begin
            r_wdat <= r_wdat;
        end else if (i_bubble) begin
            r_wsel <= '0;
            r_wen  <= 1'b0;
            r_halt <= 1'b0;
        end else begin
            r_wdat <= i_wdat;
            r_wsel <= i_wsel;
            r_wen  <= i_wen & (i_wsel != '0);
            r_halt <= i_halt;
        end
    end

    assign o_wdat = r_wdat;
    assign o_wsel = r_wsel;
    assign o_wen  = r_wen;
    assign o_halt = r_halt;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: drives data-cache requests, stalls until dhit, feeds MEM/WB and tracks halt and stall cycles.
module mem_stage
    import cpu_types_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16
)(
    input  logic       CLK,
    input  logic       RST,
    mem_stage_if.mem   bus
);

    memstate_t              r_state;
    logic [STALL_CNT_W-1:0] r_stall_cycles;

    logic     w_ren;
    logic     w_wen;
    word_t    w_addr;
    word_t    w_store;
    logic     w_stall;
    logic     w_halted;
    word_t    w_wdat_sel;
    word_t    w_wb_wdat;
    regbits_t w_wb_wsel;
    logic     w_wb_wen;
    logic     w_wb_halt;

    assign w_halted = (r_state == MS_HALTED);

    // Cache request; a store wins over a load when both are flagged
    always_comb begin
        w_ren   = 1'b0;
        w_wen   = 1'b0;
        w_addr  = '0;
        w_store = '0;
        if (!w_halted) begin
            w_wen   = bus.ex_dWEN;
            w_ren   = bus.ex_dREN & ~bus.ex_dWEN;
            w_addr  = bus.ex_port_o;
            w_store = bus.ex_rdat2;
        end
    end

    assign w_stall = (w_ren | w_wen) & ~bus.dhit;

    always_comb begin
        w_wdat_sel = bus.ex_port_o;
        case (bus.ex_wdatsel)
            WDAT_ALU:  w_wdat_sel = bus.ex_port_o;
            WDAT_LOAD: w_wdat_sel = bus.dmemload;
            WDAT_NPC:  w_wdat_sel = bus.ex_npc;
            WDAT_LUI:  w_wdat_sel = bus.ex_lui_word;
            default:   w_wdat_sel = bus.ex_port_o;
        endcase
    end

    // HALTED is absorbing; WAIT is held by the frozen EX/MEM latch until dhit
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= MS_IDLE;
        end else begin
            case (r_state)
                MS_IDLE: begin
                    if (w_stall)
                        r_state <= MS_WAIT;
                    else if (bus.ex_halt && bus.enable)
                        r_state <= MS_HALTED;
                end
                MS_WAIT: begin
                    if (bus.dhit)
                        r_state <= MS_IDLE;
                end
                MS_HALTED: r_state <= MS_HALTED;
                default:   r_state <= MS_IDLE;
            endcase
        end
    end

    // Saturating count of stalled edges, independent of enable
    always_ff @(posedge CLK) begin
        if (RST)
            r_stall_cycles <= '0;
        else if (w_stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
    end

    memwb_reg u_memwb (
        .CLK      (CLK),
        .RST      (RST),
        .i_halted (w_halted),
        .i_enable (bus.enable),
        .i_bubble (bus.flush | w_stall),
        .i_wdat   (w_wdat_sel),
        .i_wsel   (bus.ex_wsel),
        .i_wen    (bus.ex_WEN),
        .i_halt   (bus.ex_halt),
        .o_wdat   (w_wb_wdat),
        .o_wsel   (w_wb_wsel),
        .o_wen    (w_wb_wen),
        .o_halt   (w_wb_halt)
    );

    assign bus.dmemREN      = w_ren;
    assign bus.dmemWEN      = w_wen;
    assign bus.dmemaddr     = w_addr;
    assign bus.dmemstore    = w_store;
    assign bus.mem_stall    = w_stall;
    assign bus.wb_wdat      = w_wb_wdat;
    assign bus.wb_wsel      = w_wb_wsel;
    assign bus.wb_WEN       = w_wb_wen;
    assign bus.wb_halt      = w_wb_halt;
    assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, load latency, store hit, wb mux, flush/freeze, halt.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_stage_if #(.STALL_CNT_W(16)) m ();

    mem_stage #(.STALL_CNT_W(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream must never freeze the pipe while a request is outstanding
    always @(posedge clk) begin
        if (!rst)
            assert (!(m.mem_stall && !m.enable)) else $error("enable dropped with a pending request");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        m.enable      = 1'b1;
        m.flush       = 1'b0;
        m.ex_port_o   = '0;
        m.ex_rdat2    = '0;
        m.ex_npc      = '0;
        m.ex_lui_word = '0;
        m.ex_wdatsel  = WDAT_ALU;
        m.ex_wsel     = '0;
        m.ex_dREN     = 1'b0;
        m.ex_dWEN     = 1'b0;
        m.ex_WEN      = 1'b0;
        m.ex_halt     = 1'b0;
        m.dhit        = 1'b0;
        m.dmemload    = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_nop();
        m.ex_dREN    = 1'b1;
        m.ex_port_o  = 32'h0000_0100;
        m.ex_wsel    = 5'd5;
        m.ex_WEN     = 1'b1;
        m.ex_wdatsel = WDAT_LOAD;
        tick();
        tick();
        checks++; if ({m.wb_WEN, m.wb_halt, m.wb_wsel} !== 7'd0) begin errors++; $display("FAIL reset_wb_ctrl got %b expected 0", {m.wb_WEN, m.wb_halt, m.wb_wsel}); end
        checks++; if (m.wb_wdat !== 32'h0) begin errors++; $display("FAIL reset_wb_wdat got %h expected 0", m.wb_wdat); end
        checks++; if (m.stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall_cycles got %0d expected 0", m.stall_cycles); end
        checks++; if (m.dmemREN !== 1'b1 || m.dmemaddr !== 32'h100) begin errors++; $display("FAIL reset_req got ren=%b addr=%h expected ren=1 addr=100", m.dmemREN, m.dmemaddr); end
        checks++; if (dut.r_state !== MS_IDLE) begin errors++; $display("FAIL reset_state got %0d expected %0d", dut.r_state, MS_IDLE); end
    endtask

    task automatic test_load_latency();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++; if (m.mem_stall !== 1'b1) begin errors++; $display("FAIL load_stall_c%0d got %b expected 1", c, m.mem_stall); end
            tick();
            checks++; if (m.wb_WEN !== 1'b0) begin errors++; $display("FAIL load_bubble_c%0d got %b expected 0", c, m.wb_WEN); end
        end
        checks++; if (dut.r_state !== MS_WAIT) begin errors++; $display("FAIL load_wait_state got %0d expected %0d", dut.r_state, MS_WAIT); end
        m.dhit     = 1'b1;
        m.dmemload = 32'hDEAD_BEEF;
        #1;
        checks++; if (m.mem_stall !== 1'b0) begin errors++; $display("FAIL load_hit_stall got %b expected 0", m.mem_stall); end
        tick();
        checks++; if (m.wb_wdat !== 32'hDEAD_BEEF || m.wb_wsel !== 5'd5 || m.wb_WEN !== 1'b1) begin errors++; $display("FAIL load_wb got wdat=%h wsel=%0d wen=%b expected deadbeef 5 1", m.wb_wdat, m.wb_wsel, m.wb_WEN); end
        checks++; if (m.stall_cycles !== 16'd2) begin errors++; $display("FAIL load_stall_cycles got %0d expected 2", m.stall_cycles); end
        drive_nop();
        tick();
        checks++; if (m.wb_WEN !== 1'b0) begin errors++; $display("FAIL load_single_wb got %b expected 0", m.wb_WEN); end
    endtask

    task automatic test_store_hit();
        drive_nop();
        m.ex_dWEN   = 1'b1;
        m.ex_port_o = 32'h0000_0200;
        m.ex_rdat2  = 32'h1234_5678;
        m.ex_WEN    = 1'b0;
        m.dhit      = 1'b1;
        #1;
        checks++; if (m.mem_stall !== 1'b0) begin errors++; $display("FAIL store_stall got %b expected 0", m.mem_stall); end
        checks++; if (m.dmemWEN !== 1'b1 || m.dmemREN !== 1'b0) begin errors++; $display("FAIL store_strobes got wen=%b ren=%b expected 1 0", m.dmemWEN, m.dmemREN); end
        checks++; if (m.dmemstore !== 32'h1234_5678 || m.dmemaddr !== 32'h200) begin errors++; $display("FAIL store_bus got data=%h addr=%h expected 12345678 200", m.dmemstore, m.dmemaddr); end
        m.ex_dREN = 1'b1;
        #1;
        checks++; if (m.dmemREN !== 1'b0 || m.dmemWEN !== 1'b1) begin errors++; $display("FAIL store_priority got ren=%b wen=%b expected 0 1", m.dmemREN, m.dmemWEN); end
        tick();
        checks++; if (m.wb_WEN !== 1'b0 || m.stall_cycles !== 16'd2) begin errors++; $display("FAIL store_wb got wen=%b stalls=%0d expected 0 2", m.wb_WEN, m.stall_cycles); end
    endtask

    task automatic test_wb_mux();
        drive_nop();
        m.ex_npc     = 32'h0000_0044;
        m.ex_wsel    = 5'd31;
        m.ex_WEN     = 1'b1;
        m.ex_wdatsel = WDAT_NPC;
        tick();
        checks++; if (m.wb_wdat !== 32'h44 || m.wb_WEN !== 1'b1 || m.wb_wsel !== 5'd31) begin errors++; $display("FAIL wb_npc got wdat=%h wen=%b wsel=%0d expected 44 1 31", m.wb_wdat, m.wb_WEN, m.wb_wsel); end
        drive_nop();
        m.ex_lui_word = 32'hABCD_0000;
        m.ex_wsel     = 5'd0;
        m.ex_WEN      = 1'b1;
        m.ex_wdatsel  = WDAT_LUI;
        tick();
        checks++; if (m.wb_wdat !== 32'hABCD_0000 || m.wb_WEN !== 1'b0) begin errors++; $display("FAIL wb_lui_r0 got wdat=%h wen=%b expected abcd0000 0", m.wb_wdat, m.wb_WEN); end
        drive_nop();
        m.ex_port_o = 32'h0000_0055;
        m.ex_wsel   = 5'd7;
        m.ex_WEN    = 1'b1;
        tick();
        checks++; if (m.wb_wdat !== 32'h55 || m.wb_WEN !== 1'b1 || m.wb_wsel !== 5'd7) begin errors++; $display("FAIL wb_alu got wdat=%h wen=%b wsel=%0d expected 55 1 7", m.wb_wdat, m.wb_WEN, m.wb_wsel); end
    endtask

    task automatic test_flush_freeze();
        drive_nop();
        m.ex_port_o = 32'h0000_0077;
        m.ex_wsel   = 5'd3;
        m.ex_WEN    = 1'b1;
        m.flush     = 1'b1;
        tick();
        checks++; if (m.wb_WEN !== 1'b0 || m.wb_wsel !== 5'd0 || m.wb_wdat !== 32'h55) begin errors++; $display("FAIL flush_bubble got wen=%b wsel=%0d wdat=%h expected 0 0 55", m.wb_WEN, m.wb_wsel, m.wb_wdat); end
        m.flush = 1'b0;
        tick();
        checks++; if (m.wb_wdat !== 32'h77 || m.wb_WEN !== 1'b1 || m.wb_wsel !== 5'd3) begin errors++; $display("FAIL flush_recapture got wdat=%h wen=%b wsel=%0d expected 77 1 3", m.wb_wdat, m.wb_WEN, m.wb_wsel); end
        m.enable    = 1'b0;
        m.ex_port_o = 32'h0000_0099;
        m.ex_wsel   = 5'd9;
        m.ex_halt   = 1'b1;
        tick();
        tick();
        checks++; if (m.wb_wdat !== 32'h77 || m.wb_WEN !== 1'b1 || m.wb_wsel !== 5'd3 || m.wb_halt !== 1'b0) begin errors++; $display("FAIL freeze_hold got wdat=%h wen=%b wsel=%0d halt=%b expected 77 1 3 0", m.wb_wdat, m.wb_WEN, m.wb_wsel, m.wb_halt); end
        checks++; if (dut.r_state !== MS_IDLE) begin errors++; $display("FAIL freeze_no_halt got %0d expected %0d", dut.r_state, MS_IDLE); end
    endtask

    task automatic test_halt();
        drive_nop();
        m.ex_halt = 1'b1;
        tick();
        checks++; if (m.wb_halt !== 1'b1 || dut.r_state !== MS_HALTED) begin errors++; $display("FAIL halt_capture got halt=%b state=%0d expected 1 %0d", m.wb_halt, dut.r_state, MS_HALTED); end
        m.ex_halt   = 1'b0;
        m.ex_port_o = 32'h0000_0300;
        m.ex_WEN    = 1'b1;
        m.ex_wsel   = 5'd4;
        for (int c = 0; c < 4; c++) begin
            m.ex_dREN = c[0] ? 1'b0 : 1'b1;
            #1;
            checks++; if (m.dmemREN !== 1'b0 || m.dmemWEN !== 1'b0 || m.mem_stall !== 1'b0 || m.dmemaddr !== 32'h0) begin errors++; $display("FAIL halt_strobes_c%0d got ren=%b wen=%b stall=%b addr=%h expected 0 0 0 0", c, m.dmemREN, m.dmemWEN, m.mem_stall, m.dmemaddr); end
            tick();
            checks++; if (m.wb_halt !== 1'b1 || m.wb_WEN !== 1'b0) begin errors++; $display("FAIL halt_sticky_c%0d got halt=%b wen=%b expected 1 0", c, m.wb_halt, m.wb_WEN); end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (m.wb_halt !== 1'b0 || dut.r_state !== MS_IDLE || m.stall_cycles !== 16'd0) begin errors++; $display("FAIL halt_reset got halt=%b state=%0d stalls=%0d expected 0 %0d 0", m.wb_halt, dut.r_state, m.stall_cycles, MS_IDLE); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_latency();
        test_store_hit();
        test_wb_mux();
        test_flush_freeze();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
